// File: rtl/cnn_frame_streamer.sv
// Buffers one 28x28 u8 frame from a valid/ready byte source and replays it to the CNN core as one gap-free burst.
// Optional result watchdog in WAIT_RESULT: define CNN_STREAMER_RESULT_TIMEOUT_EN.
module cnn_frame_streamer #(
    parameter int NPIX           = 784,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        core_done,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {FILL, DRAIN, STEP, STREAM, WAIT_RESULT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(NPIX);

    if ((1 << ADDR_W) < NPIX || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cnn_frame_streamer: ADDR_W too small for NPIX or TIMEOUT_CYCLES < 1");
    end

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt, rd_addr;
    logic              accept, wr_en, rd_en;
    logic              rd_valid, rd_valid_nxt;
    logic              frame_err_nxt, cnt_inc;
    logic [7:0]        ram_q;
    logic [7:0]        mem [NPIX];
`ifdef CNN_STREAMER_RESULT_TIMEOUT_EN
    logic [15:0]       wd_cnt, wd_cnt_nxt;
`endif

    assign accept = s_valid & s_ready;
    assign busy   = (state == STEP) || (state == STREAM) || (state == WAIT_RESULT);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        rd_addr       = rd_ptr;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        rd_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        cnt_inc       = 1'b0;
`ifdef CNN_STREAMER_RESULT_TIMEOUT_EN
        wd_cnt_nxt    = '0;
`endif
        case (state)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_ADDR) begin
                        wr_ptr_nxt = '0;
                        if (s_last) begin
                            state_nxt = STEP;
                        end else begin
                            frame_err_nxt = 1'b1;
                            state_nxt     = DRAIN;
                        end
                    end else if (s_last) begin
                        frame_err_nxt = 1'b1;
                        wr_ptr_nxt    = '0;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) state_nxt = FILL;
            end
            STEP: begin
                rd_en        = 1'b1;
                rd_addr      = '0;
                rd_valid_nxt = 1'b1;
                rd_ptr_nxt   = ADDR_W'(1);
                state_nxt    = STREAM;
            end
            STREAM: begin
                if (rd_ptr != END_ADDR) begin
                    rd_en        = 1'b1;
                    rd_valid_nxt = 1'b1;
                    rd_ptr_nxt   = rd_ptr + 1'b1;
                end else if (data_valid && !rd_valid) begin
                    // Last pixel is on data_out now; data_valid falls at this edge.
                    state_nxt  = WAIT_RESULT;
                    cnt_inc    = 1'b1;
                    rd_ptr_nxt = '0;
                end
            end
            WAIT_RESULT: begin
`ifdef CNN_STREAMER_RESULT_TIMEOUT_EN
                if (core_done) begin
                    state_nxt = FILL;
                end else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = FILL;
                end else begin
                    wd_cnt_nxt = wd_cnt + 1'b1;
                end
`else
                if (core_done) state_nxt = FILL;
`endif
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            s_ready    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
`ifdef CNN_STREAMER_RESULT_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            rd_valid   <= rd_valid_nxt;
            s_ready    <= (state_nxt == FILL) || (state_nxt == DRAIN);
            data_out   <= rd_valid ? ram_q : 8'd0;
            data_valid <= rd_valid;
            frame_err  <= frame_err_nxt;
            if (cnt_inc) frame_cnt <= frame_cnt + 1'b1;
`ifdef CNN_STREAMER_RESULT_TIMEOUT_EN
            wd_cnt     <= wd_cnt_nxt;
`endif
        end
    end

    // NOTE: the frame buffer is deliberately not reset; its contents are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s_data;
        if (rd_en) ram_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Directed bench for cnn_frame_streamer: good, gapped, short, long and reset-aborted frames, plus the optional watchdog.
module tb_cnn_frame_streamer;

    localparam int NPIX = 784;
`ifdef CNN_STREAMER_RESULT_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        core_done;
    logic        busy;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    cnn_frame_streamer #(.NPIX(NPIX), .ADDR_W(10), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .data_out(data_out), .data_valid(data_valid),
        .core_done(core_done), .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic push_byte(input logic [7:0] d, input logic last);
        int t = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        while (s_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t == 200) check("push_ready_timeout", 32'(t), 0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int nbytes, input int off, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
            push_byte(8'(i + off), i == nbytes - 1);
            if (nbytes > NPIX && i == NPIX - 1) begin
                check("long_err_pulse", frame_err, 1);
                check("long_drain_ready", s_ready, 1);
            end
            if (nbytes > NPIX && i == NPIX) check("long_err_once", frame_err, 0);
        end
    endtask

    // Entered at the negedge just after the last byte's accepting edge.
    task automatic check_stream(input int off);
        int bad_valid = 0;
        int bad_data  = 0;
        int bad_ready = 0;
        int first_bad = -1;
        check("step_busy", busy, 1);
        check("step_ready", s_ready, 0);
        @(negedge clk);
        check("latency_valid_low", data_valid, 0);
        check("latency_dout_zero", data_out, 0);
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            if (data_valid !== 1'b1) bad_valid++;
            if (data_out !== 8'(i + off)) begin
                bad_data++;
                if (first_bad < 0) first_bad = i;
            end
            if (s_ready !== 1'b0) bad_ready++;
            core_done = (i == 400);
        end
        core_done = 1'b0;
        check("burst_valid_gaps", 32'(bad_valid), 0);
        check("burst_data_errs", 32'(bad_data), 0);
        if (bad_data != 0) check("burst_first_bad_idx", 32'(first_bad), 32'hFFFF_FFFF);
        check("burst_ready_low", 32'(bad_ready), 0);
        @(negedge clk);
        exp_cnt++;
        check("valid_fall", data_valid, 0);
        check("dout_zero_after", data_out, 0);
        check("frame_cnt", frame_cnt, 32'(exp_cnt));
        check("wait_busy", busy, 1);
        check("wait_ready", s_ready, 0);
    endtask

    task automatic finish_result();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("done_ready", s_ready, 1);
        check("done_busy", busy, 0);
        check("done_no_err", frame_err, 0);
    endtask

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_valid", data_valid, 0);
        check("rst_dout", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        check("rst_cnt", frame_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", s_ready, 1);

        // 1: back-to-back good frame
        send_frame(NPIX, 0, 1'b0);
        check_stream(0);
        finish_result();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("done_in_fill_ignored_ready", s_ready, 1);
        check("done_in_fill_ignored_busy", busy, 0);

        // 2: gapped source
        send_frame(NPIX, 0, 1'b1);
        check_stream(0);
        repeat (5) @(negedge clk);
        check("wait_holds_ready", s_ready, 0);
        check("wait_holds_busy", busy, 1);
        finish_result();

        // 3: short frame then good frame
        send_frame(100, 50, 1'b0);
        check("short_err_pulse", frame_err, 1);
        check("short_ready", s_ready, 1);
        @(negedge clk);
        check("short_err_once", frame_err, 0);
        check("short_no_valid", data_valid, 0);
        check("short_not_busy", busy, 0);
        send_frame(NPIX, 7, 1'b0);
        check_stream(7);
        finish_result();

        // 4: long frame then good frame
        send_frame(790, 3, 1'b0);
        check("long_back_fill_ready", s_ready, 1);
        check("long_no_valid", data_valid, 0);
        check("long_not_busy", busy, 0);
        send_frame(NPIX, 200, 1'b0);
        check_stream(200);
        finish_result();

        // 5: reset mid-stream
        send_frame(NPIX, 11, 1'b0);
        repeat (302) @(negedge clk);
        check("pre_abort_valid", data_valid, 1);
        check("pre_abort_data", data_out, 32'(8'(300 + 11)));
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", data_valid, 0);
        check("abort_ready", s_ready, 0);
        check("abort_cnt", frame_cnt, 0);
        exp_cnt = 0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_release_ready", s_ready, 1);
        check("abort_release_valid", data_valid, 0);
        send_frame(NPIX, 99, 1'b0);
        check_stream(99);
        finish_result();

`ifdef CNN_STREAMER_RESULT_TIMEOUT_EN
        // 6: watchdog expiry, then core_done exactly at expiry
        send_frame(NPIX, 0, 1'b0);
        check_stream(0);
        repeat (TO - 1) @(negedge clk);
        check("wd_no_early_err", frame_err, 0);
        check("wd_still_busy", busy, 1);
        @(negedge clk);
        check("wd_err_pulse", frame_err, 1);
        check("wd_ready", s_ready, 1);
        @(negedge clk);
        check("wd_err_once", frame_err, 0);
        send_frame(NPIX, 0, 1'b0);
        check_stream(0);
        repeat (TO - 2) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("wd_tie_no_err", frame_err, 0);
        check("wd_tie_ready", s_ready, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
